scan_cmd_ctrl: RTL

Serial scan command controller sitting directly upstream of the SRAM/register mux. Shifts a 48-bit command frame in from the scan chain, issues a single read or write strobe on the scan_* bus, and waits for scan_ready. Read data is loaded back into the shift register so the next shift sequence returns it on scan_out. All scan pins arrive pre-synchronised to clk.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_shift_reg.sv | 34 +++
 rtl/scan_cmd_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and frame layout for the serial scan command controller.
// Frame layout is {wr, addr[14:0], wdata[31:0]}, shifted in MSB first.
package scan_pkg;

    localparam int FRAME_W  = 48;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int WR_BIT   = 47;
    localparam int ADDR_MSB = 46;
    localparam int ADDR_LSB = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// 48-bit scan frame register: serial shift, parallel load of the low data word, or hold.
// scan_out is taken straight from the register MSB, so it only moves on shift or load.
module scan_shift_reg
    import scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_shift,
    input  logic               i_load,
    input  logic               i_bit,
    input  logic [DATA_W-1:0]  i_load_data,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_scan_out
);

    logic [FRAME_W-1:0] r_frame;

    // Shift and load never coincide: shifting is only allowed in IDLE, loading only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (i_shift) begin
            r_frame <= {r_frame[FRAME_W-2:0], i_bit};
        end else if (i_load) begin
            r_frame <= {r_frame[FRAME_W-1:DATA_W], i_load_data};
        end else begin
            r_frame <= r_frame;
        end
    end

    assign o_frame    = r_frame;
    assign o_scan_out = r_frame[FRAME_W-1];

endmodule

// File: rtl/scan_cmd_ctrl.sv
// Serial scan command controller: decodes a shifted-in frame into one read/write strobe
// on the scan bus, waits for scan_ready with a bounded timer, and captures read data.
module scan_cmd_ctrl
    import scan_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_in,
    input  logic              scan_en,
    input  logic              scan_update,
    output logic              scan_out,
    output logic              scan_ren,
    output logic              scan_wen,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_wdata,
    input  logic [DATA_W-1:0] scan_rdata,
    input  logic              scan_ready,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);

    // WAIT starts with the timer at 0 one cycle after the strobe, so the last
    // cycle that may still accept scan_ready carries timer value TIMEOUT-2.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

    state_e             r_state;
    logic               r_upd_q;
    logic               r_wr;
    logic [7:0]         r_timer;
    logic               r_ren;
    logic               r_wen;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_busy;
    logic               r_err_tmo;
    logic               r_err_ovr;

    logic [FRAME_W-1:0] w_frame;
    logic               w_upd_edge;
    logic               w_active;
    logic               w_shift;
    logic               w_load;

    // Decode of shift/load requests and the update edge for this cycle.
    always_comb begin
        w_upd_edge = scan_update & ~r_upd_q;
        w_active   = (r_state == ISSUE) || (r_state == WAIT);
        w_shift    = (r_state == IDLE) && scan_en;
        w_load     = w_active && scan_ready && !r_wr;
    end

    scan_shift_reg u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_shift     (w_shift),
        .i_load      (w_load),
        .i_bit       (scan_in),
        .i_load_data (scan_rdata),
        .o_frame     (w_frame),
        .o_scan_out  (scan_out)
    );

    // Command FSM with timer, strobes, held address/data and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_upd_q   <= 1'b0;
            r_wr      <= 1'b0;
            r_timer   <= 8'd0;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            r_upd_q <= scan_update;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_upd_edge && scan_en) begin
                        r_err_ovr <= 1'b1;
                    end else if (w_upd_edge) begin
                        r_wr      <= w_frame[WR_BIT];
                        r_addr    <= w_frame[ADDR_MSB:ADDR_LSB];
                        r_wdata   <= w_frame[DATA_W-1:0];
                        r_wen     <= w_frame[WR_BIT];
                        r_ren     <= ~w_frame[WR_BIT];
                        r_busy    <= 1'b1;
                        r_err_tmo <= 1'b0;
                        r_err_ovr <= 1'b0;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= 8'd0;
                    if (scan_en || w_upd_edge) begin
                        r_err_ovr <= 1'b1;
                    end
                    if (scan_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (TIMEOUT == 1) begin
                        r_err_tmo <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (scan_en || w_upd_edge) begin
                        r_err_ovr <= 1'b1;
                    end
                    if (scan_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_timer == TMO_LAST) begin
                        r_err_tmo <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign scan_ren    = r_ren;
    assign scan_wen    = r_wen;
    assign scan_addr   = r_addr;
    assign scan_wdata  = r_wdata;
    assign busy        = r_busy;
    assign err_timeout = r_err_tmo;
    assign err_overrun = r_err_ovr;

endmodule
